// File: rtl/uart_hex_report_sequencer.sv
// Purpose : prints a snapshotted 32-bit value as 8 uppercase ASCII hex digits (+ optional CR LF) via uart_transmitter.
// Latency : first start pulse in the cycle after the accepting edge, then one pulse every CLKS_PER_CHAR cycles.
// Backpr. : none from the transmitter (open-loop pacing); triggers while busy are dropped and flagged.
//
// Ports:
//   clk          system clock
//   i_reset      synchronous active-low reset
//   i_trigger    report request, accepted when o_busy is low
//   i_value      value to print, captured on the accepting edge
//   o_busy       sequence in progress
//   o_start_uart one-cycle start strobe for the transmitter
//   o_uart_data  character for the transmitter, held between strobes
//   o_done       one-cycle pulse at sequence completion
//   o_dropped    one-cycle pulse when a trigger arrives while busy
module uart_hex_report_sequencer #(
   parameter int CLKS_PER_CHAR = 8680,
   parameter bit SEND_NEWLINE  = 1'b1
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_trigger,
   input  logic [31:0] i_value,
   output logic        o_busy,
   output logic        o_start_uart,
   output logic [7:0]  o_uart_data,
   output logic        o_done,
   output logic        o_dropped
);

   localparam int NCHARS = SEND_NEWLINE ? 10 : 8;
   localparam int CNT_W  = $clog2(CLKS_PER_CHAR);

   // The SEND cycle itself is the first cycle of each character slot, so WAIT
   // covers the remaining CLKS_PER_CHAR-1 cycles: pace counts 0..CLKS_PER_CHAR-2.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_CHAR - 2);
   localparam logic [3:0]       IDX_LAST = 4'(NCHARS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state;
   logic [31:0]      snap;      // remaining digits, next one in [31:28]
   logic [3:0]       idx;
   logic [CNT_W-1:0] pace;
   logic [3:0]       idx_nxt;
   logic [7:0]       next_char;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      else             return 8'h37 + {4'h0, nib};
   endfunction

   // Character for the slot after the current one.
   always_comb begin
      idx_nxt   = idx + 4'd1;
      next_char = hex_ascii(snap[31:28]);
      if (idx_nxt == 4'd8)      next_char = 8'h0D;
      else if (idx_nxt == 4'd9) next_char = 8'h0A;
   end

   always_ff @(posedge clk) begin
      if (!i_reset) begin
         state        <= S_IDLE;
         snap         <= 32'h0;
         idx          <= 4'd0;
         pace         <= '0;
         o_busy       <= 1'b0;
         o_start_uart <= 1'b0;
         o_uart_data  <= 8'h00;
         o_done       <= 1'b0;
         o_dropped    <= 1'b0;
      end else begin
         o_start_uart <= 1'b0;
         o_done       <= 1'b0;
         o_dropped    <= i_trigger & o_busy;
         case (state)
            // DONE accepts like IDLE so reports can run back to back.
            S_IDLE, S_DONE: begin
               if (i_trigger) begin
                  // Digit 0 goes out directly from i_value; the snapshot keeps
                  // the remaining digits pre-shifted.
                  state        <= S_SEND;
                  snap         <= {i_value[27:0], 4'h0};
                  idx          <= 4'd0;
                  pace         <= '0;
                  o_uart_data  <= hex_ascii(i_value[31:28]);
                  o_start_uart <= 1'b1;
                  o_busy       <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SEND: begin
               state <= S_WAIT;
               pace  <= '0;
            end
            S_WAIT: begin
               if (pace == CNT_LAST) begin
                  if (idx == IDX_LAST) begin
                     state  <= S_DONE;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                  end else begin
                     state        <= S_SEND;
                     idx          <= idx_nxt;
                     snap         <= {snap[27:0], 4'h0};
                     o_uart_data  <= next_char;
                     o_start_uart <= 1'b1;
                  end
               end else begin
                  pace <= pace + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_hex_report_sequencer.md
Name: uart_hex_report_sequencer

Overview:
Sequences the shared uart_transmitter to print a 32-bit value, such as the counter output, as ASCII hex. Each accepted request snapshots the value and emits 8 uppercase hex digits, MSB first, optionally followed by CR LF. The uart_transmitter has no busy/ready output, so characters are paced open-loop: one start pulse every CLKS_PER_CHAR cycles. The block replaces the counter's direct o_start_uart/o_uart_data drive into the transmitter.

Parameters:
CLKS_PER_CHAR, 8680, cycles between successive start pulses (one full UART frame, 10 bits × 868 at 100 MHz/115200); legal range >= 2.
SEND_NEWLINE, 1, 1 = append 0x0D 0x0A after the digits; 0 = digits only.

Ports:
clk  input  1  system clock, single clock domain
i_reset  input  1  synchronous reset, active-low (0 = reset, sampled on the rising edge of clk)
i_trigger  input  1  report request, sampled every edge, level or pulse
i_value  input  32  value to print, sampled only on the accepting edge
o_busy  output  1  sequence in progress
o_start_uart  output  1  one-cycle start pulse to uart_transmitter i_start_transmission
o_uart_data  output  8  ASCII character to uart_transmitter i_data
o_done  output  1  one-cycle pulse when a sequence completes
o_dropped  output  1  one-cycle pulse when a trigger is rejected

Behaviour:
- NCHARS = 10 if SEND_NEWLINE, else 8. All outputs are registered.
- Reset: i_reset==0 at an edge forces the following:
  - state IDLE, snapshot = 0, char index = 0, pace counter = 0;
  - o_busy, o_start_uart, o_done and o_dropped all 0; o_uart_data = 0x00;
  - reset wins over i_trigger on the same edge;
  - a sequence in progress is aborted: no further start pulses and no o_done.
- FSM states: IDLE, SEND, WAIT, DONE.
  - IDLE: i_trigger=1 at an edge is accepted. The block captures i_value into the snapshot, sets index = 0 and moves to SEND.
  - SEND: loads the character, pulses start and goes to WAIT.
  - WAIT: counts CLKS_PER_CHAR-1 cycles, then either increments the index and returns to SEND, or goes to DONE after index NCHARS-1.
  - DONE: pulses o_done and returns to IDLE.
- Cycle-level timing, with the trigger accepted at edge k:
  - Start pulse for char i is high in exactly the one cycle after edge k + i*CLKS_PER_CHAR, for i = 0..NCHARS-1.
  - o_uart_data shows char i in that same cycle and is held stable until the next start pulse. After the last character it holds until the next sequence or reset.
  - o_busy=1 from the cycle after edge k through the cycle after edge k + NCHARS*CLKS_PER_CHAR - 1.
  - o_done=1 and o_busy=0 in the cycle after edge k + NCHARS*CLKS_PER_CHAR.
- Character mapping:
  - Digit i is nibble snapshot[31-4i : 28-4i].
  - Nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46 (uppercase only).
  - Chars 8 and 9 (SEND_NEWLINE=1) are 0x0D and 0x0A.
- Acceptance rule: i_trigger is accepted iff o_busy==0 at the sampling edge. This includes the o_done cycle, which allows back-to-back reports with no idle gap beyond the DONE cycle.
- A trigger sampled while o_busy==1 is ignored and o_dropped=1 for the next cycle. The running sequence is unaffected and nothing is queued.
- Changes to i_value after the accepting edge have no effect on the sequence in progress.
- The pace counter is $clog2(CLKS_PER_CHAR) bits wide and must not wrap or saturate incorrectly at the CLKS_PER_CHAR limit.
- No combinational path from any input to any output.

Test Plan:
1. CLKS_PER_CHAR=16, SEND_NEWLINE=1, i_value=0x0123ABEF, trigger at edge k -> start pulses at k+1, k+17, …, k+145 carrying 30 31 32 33 41 42 45 46 0D 0A; o_done in the cycle after k+160; o_busy high for exactly 160 cycles.
2. SEND_NEWLINE=0, i_value=0xFFFFFFFF, then 0x00000000 -> first run gives eight 0x46 and o_done after k+128; second gives eight 0x30; exactly 8 start pulses per run.
3. Trigger again at k+50 with i_value changed to 0x12345678 -> one o_dropped pulse at k+51; emitted characters are still those of 0x0123ABEF; no extra start pulses.
4. Hold i_trigger=1 continuously -> a new sequence is accepted at each o_done cycle; the next start pulse follows o_done by exactly one cycle; o_dropped pulses on every busy cycle.
5. Drive i_reset=0 for one edge during WAIT after char 4 -> the next cycle has all outputs 0 and o_uart_data=0x00; no o_done and no further start pulses; a later trigger restarts from digit 0 of the new i_value.
6. i_reset=0 and i_trigger=1 on the same edge -> stays IDLE with o_busy=0; the trigger is neither accepted nor flagged dropped.
